arbiter_rr_lock: RTL and testbench

//  Parametrised N-way round-robin arbiter with a registered priority pointer and wormhole packet lock.

---
 rtl/arbiter_rr_lock_if.sv | 38 +++
 rtl/arbiter_rr_lock.sv | 106 ++++++++++
 tb/tb_arbiter_rr_lock.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr_lock_if.sv
// Arbitration bus between the requesters and the round-robin arbiter.
// The master side drives requests and the downstream ready.
// The slave side (the arbiter) returns the grant and its status.
interface arbiter_rr_lock_if #(
    parameter int N = 4,
    parameter int W = (N > 2) ? $clog2(N) : 1
);
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         grant_ready;
    logic         grant_valid;
    logic [N-1:0] grant_oh;
    logic [W-1:0] grant_bin;
    logic         locked;
    logic [W-1:0] low_pr;

    modport master (
        output req,
        output last,
        output grant_ready,
        input  grant_valid,
        input  grant_oh,
        input  grant_bin,
        input  locked,
        input  low_pr
    );

    modport slave (
        input  req,
        input  last,
        input  grant_ready,
        output grant_valid,
        output grant_oh,
        output grant_bin,
        output locked,
        output low_pr
    );
endinterface

// File: rtl/arbiter_rr_lock.sv
// N-way round-robin arbiter with a registered priority pointer and wormhole lock.
// A head flit that wins keeps the grant for its requester until the tail is accepted.
// The grant is combinational from req and state.
// The pointer and lock only move on an accepted transfer.
module arbiter_rr_lock #(
    parameter int N        = 4,
    parameter int W        = (N > 2) ? $clog2(N) : 1,
    parameter bit LOCK_EN  = 1'b1,
    parameter int RESET_PR = N - 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    arbiter_rr_lock_if.slave arb_io
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [W-1:0]   low_pr_q;
    logic [W-1:0]   low_pr_d;
    logic [W-1:0]   owner_q;
    logic [W-1:0]   owner_d;

    logic           anyReq;
    logic [W-1:0]   rrWinner;
    logic [W-1:0]   candIdx;
    int             cand;
    logic           grantValid;
    logic [W-1:0]   grantIdx;
    logic           transfer;

    // Scan from the requester after the pointer, wrapping so the last winner is checked last.
    always_comb begin
        anyReq   = 1'b0;
        rrWinner = '0;
        candIdx  = '0;
        cand     = 0;
        for (int off = 1; off <= N; off++) begin
            cand = int'(low_pr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            candIdx = W'(cand);
            if (!anyReq && arb_io.req[candIdx]) begin
                anyReq   = 1'b1;
                rrWinner = candIdx;
            end
        end
    end

    // Pick the presented grant, then present it (everything reads zero while reset is held).
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        if (state_q == LOCKED) begin
            grantValid = arb_io.req[owner_q];
            grantIdx   = owner_q;
        end else begin
            grantValid = anyReq;
            grantIdx   = rrWinner;
        end
        transfer = grantValid & arb_io.grant_ready;

        arb_io.grant_valid = rst_ni & grantValid;
        arb_io.grant_bin   = (rst_ni && grantValid) ? grantIdx : '0;
        arb_io.grant_oh    = (rst_ni && grantValid) ? (N'(1) << grantIdx) : '0;
        arb_io.locked      = rst_ni && (state_q == LOCKED);
        arb_io.low_pr      = rst_ni ? low_pr_q : '0;
    end

    // Next state: a transfer in IDLE moves the pointer and may lock; a tail in LOCKED releases.
    always_comb begin
        state_d  = state_q;
        low_pr_d = low_pr_q;
        owner_d  = owner_q;
        if (transfer) begin
            if (state_q == IDLE) begin
                low_pr_d = grantIdx;
                if (LOCK_EN && !arb_io.last[grantIdx]) begin
                    owner_d = grantIdx;
                    state_d = LOCKED;
                end
            end else if (arb_io.last[owner_q]) begin
                state_d = IDLE;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            low_pr_q <= W'(RESET_PR);
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            low_pr_q <= low_pr_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Bench for arbiter_rr_lock: directed scenarios plus randomized traffic against a packet-level model.
module tb_arbiter_rr_lock;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arbiter_rr_lock_if #(.N(4), .W(2)) ifA ();
    arbiter_rr_lock_if #(.N(4), .W(2)) ifB ();
    arbiter_rr_lock_if #(.N(3), .W(2)) ifC ();

    assign ifB.req         = ifA.req;
    assign ifB.last        = ifA.last;
    assign ifB.grant_ready = ifA.grant_ready;

    arbiter_rr_lock #(.N(4), .W(2), .LOCK_EN(1'b1), .RESET_PR(3)) dutLock (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_io (ifA.slave)
    );

    arbiter_rr_lock #(.N(4), .W(2), .LOCK_EN(1'b0), .RESET_PR(3)) dutNoLock (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_io (ifB.slave)
    );

    arbiter_rr_lock #(.N(3), .W(2), .LOCK_EN(1'b1), .RESET_PR(2)) dutN3 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_io (ifC.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packet-level model: index 0 mirrors dutLock, index 1 mirrors dutNoLock.
    int mLowPr  [2];
    bit mLocked [2];
    int mOwner  [2];
    bit mLockEn [2] = '{1'b1, 1'b0};

    function automatic void mReset();
        for (int m = 0; m < 2; m++) begin
            mLowPr[m]  = 3;
            mLocked[m] = 1'b0;
            mOwner[m]  = 0;
        end
    endfunction

    // Who should hold the grant: the packet owner, or the first requester after the last winner.
    function automatic void mExpect(input int m, input logic [3:0] r, output bit v, output int idx);
        int order [4];
        v   = 1'b0;
        idx = 0;
        if (mLocked[m]) begin
            v   = r[mOwner[m]];
            idx = v ? mOwner[m] : 0;
        end else begin
            for (int k = 0; k < 4; k++) order[k] = (mLowPr[m] + 1 + k) % 4;
            for (int k = 0; k < 4; k++) begin
                if (!v && r[order[k]]) begin
                    v   = 1'b1;
                    idx = order[k];
                end
            end
        end
    endfunction

    function automatic void mAdvance(input int m, input logic [3:0] r, input logic [3:0] l, input logic rdy);
        bit v;
        int idx;
        mExpect(m, r, v, idx);
        if (v && rdy) begin
            if (mLocked[m]) begin
                if (l[idx]) mLocked[m] = 1'b0;
            end else begin
                mLowPr[m] = idx;
                if (mLockEn[m] && !l[idx]) begin
                    mLocked[m] = 1'b1;
                    mOwner[m]  = idx;
                end
            end
        end
    endfunction

    // Expected {grant_valid, grant_bin, grant_oh, locked, low_pr}.
    function automatic logic [9:0] expVec(input int m, input logic [3:0] r);
        bit v;
        int idx;
        logic [3:0] oh;
        logic [1:0] bn;
        logic [1:0] lp;
        mExpect(m, r, v, idx);
        oh = v ? (4'b0001 << idx) : 4'b0000;
        bn = 2'(idx);
        lp = 2'(mLowPr[m]);
        return {v, bn, oh, mLocked[m], lp};
    endfunction

    function automatic logic [9:0] actVec(input int m);
        if (m == 0) return {ifA.grant_valid, ifA.grant_bin, ifA.grant_oh, ifA.locked, ifA.low_pr};
        return {ifB.grant_valid, ifB.grant_bin, ifB.grant_oh, ifB.locked, ifB.low_pr};
    endfunction

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        ifA.req         = r;
        ifA.last        = l;
        ifA.grant_ready = rdy;
        #2;
    endtask

    task automatic applyStimulus3(input logic [2:0] r, input logic [2:0] l, input logic rdy);
        ifC.req         = r;
        ifC.last        = l;
        ifC.grant_ready = rdy;
        #2;
    endtask

    // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
    task automatic clockEdge();
        @(posedge clk);
        if (!rst_n) begin
            mReset();
        end else begin
            for (int m = 0; m < 2; m++) mAdvance(m, ifA.req, ifA.last, ifA.grant_ready);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checks++;
        if (actVec(0) !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_forced_zero act=%b exp=%b", actVec(0), 10'b0);
        end
        clockEdge();
        rst_n = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (actVec(0) !== 10'b0_00_0000_0_11) begin
            errors++;
            $display("[TB] FAIL reset_state act=%b exp=%b", actVec(0), 10'b0_00_0000_0_11);
        end
        checks++;
        if (actVec(0) !== expVec(0, ifA.req)) begin
            errors++;
            $display("[TB] FAIL reset_model act=%b exp=%b", actVec(0), expVec(0, ifA.req));
        end
        clockEdge();
    endtask

    task automatic test_round_robin();
        logic [1:0] binExp [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] lpExp  [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1);
            checks++;
            if (ifA.grant_bin !== binExp[k] || ifA.low_pr !== lpExp[k] || ifA.grant_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_sequence k=%0d bin=%0d low_pr=%0d valid=%b exp bin=%0d low_pr=%0d valid=1",
                         k, ifA.grant_bin, ifA.low_pr, ifA.grant_valid, binExp[k], lpExp[k]);
            end
            checks++;
            if (actVec(0) !== expVec(0, ifA.req)) begin
                errors++;
                $display("[TB] FAIL rr_model k=%0d act=%b exp=%b", k, actVec(0), expVec(0, ifA.req));
            end
            clockEdge();
        end
    endtask

    task automatic test_wrap();
        logic [1:0] binExp [2] = '{2'd0, 2'd1};
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        clockEdge();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0011, 4'b0011, 1'b1);
            checks++;
            if (ifA.grant_bin !== binExp[k] || ifA.grant_oh !== (4'b0001 << binExp[k])) begin
                errors++;
                $display("[TB] FAIL wrap k=%0d bin=%0d oh=%b exp bin=%0d", k, ifA.grant_bin, ifA.grant_oh, binExp[k]);
            end
            clockEdge();
        end
    endtask

    task automatic test_lock_packet();
        logic lockExp [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0101, (k == 2) ? 4'b0100 : 4'b0000, 1'b1);
            checks++;
            if (ifA.grant_bin !== 2'd2 || ifA.grant_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lock_grant flit=%0d bin=%0d valid=%b exp bin=2 valid=1", k, ifA.grant_bin, ifA.grant_valid);
            end
            checks++;
            if (ifB.locked !== 1'b0) begin
                errors++;
                $display("[TB] FAIL nolock_locked flit=%0d act=%b exp=0", k, ifB.locked);
            end
            clockEdge();
            checks++;
            if (ifA.locked !== lockExp[k]) begin
                errors++;
                $display("[TB] FAIL lock_state flit=%0d act=%b exp=%b", k, ifA.locked, lockExp[k]);
            end
        end
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        checks++;
        if (ifA.grant_bin !== 2'd0 || ifA.grant_valid !== 1'b1 || ifA.low_pr !== 2'd2) begin
            errors++;
            $display("[TB] FAIL lock_release bin=%0d valid=%b low_pr=%0d exp bin=0 valid=1 low_pr=2",
                     ifA.grant_bin, ifA.grant_valid, ifA.low_pr);
        end
        clockEdge();
    endtask

    task automatic test_bubble();
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        clockEdge();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b1000, 4'b1000, 1'b1);
            checks++;
            if ({ifA.grant_valid, ifA.grant_oh, ifA.grant_bin, ifA.locked} !== {1'b0, 4'b0000, 2'd0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bubble k=%0d valid=%b oh=%b bin=%0d locked=%b exp valid=0 oh=0000 bin=0 locked=1",
                         k, ifA.grant_valid, ifA.grant_oh, ifA.grant_bin, ifA.locked);
            end
            clockEdge();
        end
        applyStimulus(4'b1010, 4'b0010, 1'b1);
        checks++;
        if (ifA.grant_bin !== 2'd1 || ifA.grant_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bubble_resume bin=%0d valid=%b exp bin=1 valid=1", ifA.grant_bin, ifA.grant_valid);
        end
        clockEdge();
        checks++;
        if (ifA.locked !== 1'b0 || ifA.low_pr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bubble_tail locked=%b low_pr=%0d exp locked=0 low_pr=1", ifA.locked, ifA.low_pr);
        end
    endtask

    task automatic test_back_pressure();
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        clockEdge();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0110, 4'b0110, 1'b0);
            checks++;
            if ({ifA.grant_bin, ifA.low_pr, ifA.locked} !== {2'd1, 2'd3, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall k=%0d bin=%0d low_pr=%0d locked=%b exp bin=1 low_pr=3 locked=0",
                         k, ifA.grant_bin, ifA.low_pr, ifA.locked);
            end
            clockEdge();
        end
        applyStimulus(4'b0110, 4'b0110, 1'b1);
        clockEdge();
        checks++;
        if (ifA.low_pr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL stall_release low_pr=%0d exp=1", ifA.low_pr);
        end
    endtask

    task automatic test_reset_mid_packet();
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        clockEdge();
        checks++;
        if (ifA.locked !== 1'b1 || ifA.low_pr !== 2'd2) begin
            errors++;
            $display("[TB] FAIL midpkt_setup locked=%b low_pr=%0d exp locked=1 low_pr=2", ifA.locked, ifA.low_pr);
        end
        rst_n = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        clockEdge();
        rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checks++;
        if ({ifA.locked, ifA.low_pr, ifA.grant_bin, ifA.grant_valid} !== {1'b0, 2'd3, 2'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midpkt_reset locked=%b low_pr=%0d bin=%0d valid=%b exp locked=0 low_pr=3 bin=0 valid=1",
                     ifA.locked, ifA.low_pr, ifA.grant_bin, ifA.grant_valid);
        end
        clockEdge();
    endtask

    task automatic test_n3();
        logic [1:0] binExp [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        applyStimulus3(3'b111, 3'b111, 1'b0);
        checks++;
        if ({ifC.grant_valid, ifC.grant_bin, ifC.grant_oh, ifC.low_pr} !== {1'b1, 2'd0, 3'b001, 2'd2}) begin
            errors++;
            $display("[TB] FAIL n3_wrap valid=%b bin=%0d oh=%b low_pr=%0d exp valid=1 bin=0 oh=001 low_pr=2",
                     ifC.grant_valid, ifC.grant_bin, ifC.grant_oh, ifC.low_pr);
        end
        clockEdge();
        applyStimulus3(3'b000, 3'b000, 1'b1);
        checks++;
        if ({ifC.grant_valid, ifC.grant_bin, ifC.grant_oh} !== {1'b0, 2'd0, 3'b000}) begin
            errors++;
            $display("[TB] FAIL n3_idle valid=%b bin=%0d oh=%b exp valid=0 bin=0 oh=000",
                     ifC.grant_valid, ifC.grant_bin, ifC.grant_oh);
        end
        clockEdge();
        for (int k = 0; k < 4; k++) begin
            applyStimulus3(3'b111, 3'b111, 1'b1);
            checks++;
            if (ifC.grant_bin !== binExp[k] || ifC.grant_oh !== (3'b001 << binExp[k])) begin
                errors++;
                $display("[TB] FAIL n3_rotate k=%0d bin=%0d oh=%b exp bin=%0d", k, ifC.grant_bin, ifC.grant_oh, binExp[k]);
            end
            clockEdge();
        end
        applyStimulus3(3'b000, 3'b000, 1'b0);
    endtask

    task automatic test_random();
        logic [9:0] e;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            for (int m = 0; m < 2; m++) begin
                e = rst_n ? expVec(m, ifA.req) : 10'b0;
                checks++;
                if (actVec(m) !== e) begin
                    errors++;
                    $display("[TB] FAIL random dut=%0d cycle=%0d req=%b last=%b rdy=%b act=%b exp=%b",
                             m, i, ifA.req, ifA.last, ifA.grant_ready, actVec(m), e);
                end
            end
            clockEdge();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifA.req = '0;
        ifA.last = '0;
        ifA.grant_ready = 1'b0;
        ifC.req = '0;
        ifC.last = '0;
        ifC.grant_ready = 1'b0;
        mReset();
        #1;
        test_reset();
        test_round_robin();
        test_wrap();
        test_lock_packet();
        test_bubble();
        test_back_pressure();
        test_reset_mid_packet();
        test_n3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
